// File: rtl/fwd_pkg.sv
// Shared types, encodings and helpers for the forwarding/hazard controller.
// Build option: FWD_STALL_CNT_EN adds a stall counter (see fwd_hazard_ctrl).
package fwd_pkg;

    localparam int unsigned SLOT_REG_W  = 5;
    localparam int unsigned SLOT_TNEW_W = 2;
    localparam int unsigned SEL_W       = 2;

    localparam logic [SEL_W-1:0] FWD_RF = 2'd0;
    localparam logic [SEL_W-1:0] FWD_M  = 2'd1;
    localparam logic [SEL_W-1:0] FWD_W  = 2'd2;

    localparam logic [SLOT_TNEW_W-1:0] TNEW_ALU  = 2'd1;
    localparam logic [SLOT_TNEW_W-1:0] TNEW_LOAD = 2'd2;

    localparam logic [SLOT_TNEW_W-1:0] TUSE_BR  = 2'd0;
    localparam logic [SLOT_TNEW_W-1:0] TUSE_ALU = 2'd1;
    localparam logic [SLOT_TNEW_W-1:0] TUSE_ST  = 2'd2;

    typedef struct packed {
        logic [SLOT_REG_W-1:0]  dst;
        logic [SLOT_TNEW_W-1:0] tnew;
        logic [SLOT_REG_W-1:0]  rs;
        logic [SLOT_TNEW_W-1:0] pad_unused;
        logic [SLOT_REG_W-1:0]  rt;
    } slot_t;

    function automatic logic [SLOT_TNEW_W-1:0] tnew_dec(input logic [SLOT_TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - SLOT_TNEW_W'(1);
    endfunction

    // Register $0 is hard-wired, so it never produces a dependency.
    function automatic logic reg_match(input logic [SLOT_REG_W-1:0] dst,
                                       input logic [SLOT_REG_W-1:0] r);
        return (r != '0) && (dst == r);
    endfunction

    function automatic logic src_stall(input logic [SLOT_REG_W-1:0]  r,
                                       input logic [SLOT_TNEW_W-1:0] tuse,
                                       input logic [SLOT_REG_W-1:0]  e_dst,
                                       input logic [SLOT_TNEW_W-1:0] e_tnew,
                                       input logic [SLOT_REG_W-1:0]  m_dst,
                                       input logic [SLOT_TNEW_W-1:0] m_tnew);
        return (reg_match(e_dst, r) && (e_tnew > tuse)) ||
               (reg_match(m_dst, r) && (m_tnew > tuse));
    endfunction

    // Younger producer (M) wins over W when both hold the register.
    function automatic logic [SEL_W-1:0] fwd_select(input logic [SLOT_REG_W-1:0]  r,
                                                    input logic [SLOT_REG_W-1:0]  m_dst,
                                                    input logic [SLOT_TNEW_W-1:0] m_tnew,
                                                    input logic [SLOT_REG_W-1:0]  w_dst);
        if (reg_match(m_dst, r) && (m_tnew == '0)) begin
            return FWD_M;
        end
        if (reg_match(w_dst, r)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// D-stage operand/producer bundle and the controller's stall/select outputs.
interface fwd_hazard_ctrl_if #(
    parameter int unsigned REG_W  = 5,
    parameter int unsigned TNEW_W = 2
);
    logic              valid_d;
    logic [REG_W-1:0]  rs_d;
    logic [REG_W-1:0]  rt_d;
    logic [TNEW_W-1:0] tuse_rs_d;
    logic [TNEW_W-1:0] tuse_rt_d;
    logic [REG_W-1:0]  dst_d;
    logic [TNEW_W-1:0] tnew_d;

    logic       stall;
    logic [1:0] fwd_rs_d;
    logic [1:0] fwd_rt_d;
    logic [1:0] fwd_rs_e;
    logic [1:0] fwd_rt_e;

    modport master (
        output valid_d, rs_d, rt_d, tuse_rs_d, tuse_rt_d, dst_d, tnew_d,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e
    );

    modport slave (
        input  valid_d, rs_d, rt_d, tuse_rs_d, tuse_rt_d, dst_d, tnew_d,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e
    );
endinterface

// File: rtl/fwd_pipe_slot.sv
// One pipeline tracking slot: loads a producer record or a bubble each edge,
// optionally ages its tnew and optionally drops the source fields.
module fwd_pipe_slot
    import fwd_pkg::*;
#(
    parameter bit DEC_TNEW = 1'b1,
    parameter bit KEEP_SRC = 1'b1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  load_i,
    input  slot_t slot_i,
    output slot_t slot_o
);

    slot_t slot_d;
    slot_t slot_q;

    always_comb begin
        slot_d = '0;
        if (load_i) begin
            slot_d = slot_i;
            if (DEC_TNEW) begin
                slot_d.tnew = tnew_dec(slot_i.tnew);
            end
            if (!KEEP_SRC) begin
                slot_d.rs = '0;
                slot_d.rt = '0;
            end
            slot_d.pad_unused = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Stall and forwarding-select generation from E/M/W producer tracking slots.
// Build option FWD_STALL_CNT_EN adds a 32-bit wrapping stall_cnt output.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int unsigned REG_W  = SLOT_REG_W,
    parameter int unsigned TNEW_W = SLOT_TNEW_W
) (
    input  logic             clk,
    input  logic             reset,
    fwd_hazard_ctrl_if.slave bus
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    logic [REG_W-1:0]  rs_w;
    logic [REG_W-1:0]  rt_w;
    logic [REG_W-1:0]  dst_w;
    logic [TNEW_W-1:0] tuse_rs_w;
    logic [TNEW_W-1:0] tuse_rt_w;
    logic [TNEW_W-1:0] tnew_w;

    logic [SLOT_REG_W-1:0]  rs_s;
    logic [SLOT_REG_W-1:0]  rt_s;
    logic [SLOT_TNEW_W-1:0] tuse_rs_s;
    logic [SLOT_TNEW_W-1:0] tuse_rt_s;

    slot_t slot_in_d;
    slot_t slot_e;
    slot_t slot_m;
    slot_t slot_w;
    logic  stall_c;
    logic  load_e_c;
    logic  unused_src;

    assign rs_w      = bus.rs_d;
    assign rt_w      = bus.rt_d;
    assign dst_w     = bus.dst_d;
    assign tuse_rs_w = bus.tuse_rs_d;
    assign tuse_rt_w = bus.tuse_rt_d;
    assign tnew_w    = bus.tnew_d;

    assign rs_s      = SLOT_REG_W'(rs_w);
    assign rt_s      = SLOT_REG_W'(rt_w);
    assign tuse_rs_s = SLOT_TNEW_W'(tuse_rs_w);
    assign tuse_rt_s = SLOT_TNEW_W'(tuse_rt_w);

    assign slot_in_d = '{dst:        SLOT_REG_W'(dst_w),
                         tnew:       SLOT_TNEW_W'(tnew_w),
                         rs:         rs_s,
                         pad_unused: '0,
                         rt:         rt_s};

    // A stalled or empty D slot enters E as a bubble.
    assign load_e_c = bus.valid_d && !stall_c;

    fwd_pipe_slot #(.DEC_TNEW(1'b0), .KEEP_SRC(1'b1)) u_slot_e (
        .clk    (clk),
        .rst    (reset),
        .load_i (load_e_c),
        .slot_i (slot_in_d),
        .slot_o (slot_e)
    );

    fwd_pipe_slot #(.DEC_TNEW(1'b1), .KEEP_SRC(1'b1)) u_slot_m (
        .clk    (clk),
        .rst    (reset),
        .load_i (1'b1),
        .slot_i (slot_e),
        .slot_o (slot_m)
    );

    fwd_pipe_slot #(.DEC_TNEW(1'b1), .KEEP_SRC(1'b0)) u_slot_w (
        .clk    (clk),
        .rst    (reset),
        .load_i (1'b1),
        .slot_i (slot_m),
        .slot_o (slot_w)
    );

    assign stall_c = bus.valid_d &&
        (src_stall(rs_s, tuse_rs_s, slot_e.dst, slot_e.tnew, slot_m.dst, slot_m.tnew) ||
         src_stall(rt_s, tuse_rt_s, slot_e.dst, slot_e.tnew, slot_m.dst, slot_m.tnew));

    assign bus.stall    = stall_c;
    assign bus.fwd_rs_d = fwd_select(rs_s,      slot_m.dst, slot_m.tnew, slot_w.dst);
    assign bus.fwd_rt_d = fwd_select(rt_s,      slot_m.dst, slot_m.tnew, slot_w.dst);
    assign bus.fwd_rs_e = fwd_select(slot_e.rs, slot_m.dst, slot_m.tnew, slot_w.dst);
    assign bus.fwd_rt_e = fwd_select(slot_e.rt, slot_m.dst, slot_m.tnew, slot_w.dst);

    // Source fields of M and W, the E pad and W tnew play no role in selection.
    assign unused_src = ^{slot_m.rs, slot_m.rt, slot_m.pad_unused,
                          slot_w.rs, slot_w.rt, slot_w.pad_unused, slot_w.tnew,
                          slot_e.pad_unused};

`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    assign stall_cnt_d = stall_c ? stall_cnt_q + 32'd1 : stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed scenarios plus randomized traffic against an age-based producer history model.
module tb_fwd_hazard_ctrl;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned TNEW_W = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl_if #(.REG_W(REG_W), .TNEW_W(TNEW_W)) bus ();

`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    fwd_hazard_ctrl #(.REG_W(REG_W), .TNEW_W(TNEW_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FWD_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // Model: instructions that entered E, newest first; index = cycles since E entry.
    typedef struct { int dst; int tnew; int rs; int rt; } ent_t;
    ent_t hist[$];

    function automatic void model_clear();
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back('{0, 0, 0, 0});
    endfunction

    function automatic int rem(int age);
        return (hist[age].tnew > age) ? hist[age].tnew - age : 0;
    endfunction

    function automatic bit holds(int age, int r);
        return (r != 0) && (hist[age].dst == r);
    endfunction

    function automatic bit needs_stall(int r, int tuse);
        for (int a = 0; a < 2; a++)
            if (holds(a, r) && rem(a) > tuse) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int exp_sel(int r);
        if (holds(1, r) && rem(1) == 0) return 1;
        if (holds(2, r)) return 2;
        return 0;
    endfunction

    task automatic drive(input bit v, input int rs, input int trs, input int rt,
                         input int trt, input int dst, input int tnew);
        bus.valid_d   = v;
        bus.rs_d      = REG_W'(rs);
        bus.tuse_rs_d = TNEW_W'(trs);
        bus.rt_d      = REG_W'(rt);
        bus.tuse_rt_d = TNEW_W'(trt);
        bus.dst_d     = REG_W'(dst);
        bus.tnew_d    = TNEW_W'(tnew);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1, 8 + i, i % 3, 8, 0, 8, 2);
            #1;
            n_cmp++;
            if (bus.stall !== 1'b0 || bus.fwd_rs_d !== 2'd0 || bus.fwd_rt_d !== 2'd0 ||
                bus.fwd_rs_e !== 2'd0 || bus.fwd_rt_e !== 2'd0) begin
                n_err++;
                $display("FAIL reset_outputs[%0d]: stall=%0b fwd=%0d/%0d/%0d/%0d, expected all 0",
                         i, bus.stall, bus.fwd_rs_d, bus.fwd_rt_d, bus.fwd_rs_e, bus.fwd_rt_e);
            end
        end
`ifdef FWD_STALL_CNT_EN
        n_cmp++;
        if (stall_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
        end
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_alu_alu();
        apply_reset();
        @(negedge clk); drive(1, 0, 2, 0, 2, 8, 1); #1;
        @(negedge clk); drive(1, 8, 1, 0, 2, 9, 1); #1;
        n_cmp++;
        if (bus.stall !== 1'b0) begin
            n_err++; $display("FAIL alu_alu_stall: got %0b expected 0", bus.stall);
        end
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0); #1;
        n_cmp++;
        if (bus.fwd_rs_e !== 2'd1) begin
            n_err++; $display("FAIL alu_alu_fwd_rs_e: got %0d expected 1", bus.fwd_rs_e);
        end
        @(negedge clk); drive(1, 8, 0, 0, 0, 0, 0); #1;
        n_cmp++;
        if (bus.stall !== 1'b0 || bus.fwd_rs_d !== 2'd2) begin
            n_err++;
            $display("FAIL alu_alu_in_w: stall=%0b fwd_rs_d=%0d expected 0/2", bus.stall, bus.fwd_rs_d);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        @(negedge clk); drive(1, 0, 2, 0, 2, 8, 2); #1;
        @(negedge clk); drive(1, 0, 2, 8, 1, 10, 1); #1;
        n_cmp++;
        if (bus.stall !== 1'b1) begin
            n_err++; $display("FAIL load_use_stall1: got %0b expected 1", bus.stall);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (bus.stall !== 1'b0) begin
            n_err++; $display("FAIL load_use_stall2: got %0b expected 0", bus.stall);
        end
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0); #1;
        n_cmp++;
        if (bus.fwd_rt_e !== 2'd2) begin
            n_err++; $display("FAIL load_use_fwd_rt_e: got %0d expected 2", bus.fwd_rt_e);
        end
    endtask

    task automatic test_load_branch();
        apply_reset();
        @(negedge clk); drive(1, 0, 2, 0, 2, 8, 2); #1;
        @(negedge clk); drive(1, 8, 0, 0, 2, 0, 0); #1;
        n_cmp++;
        if (bus.stall !== 1'b1) begin
            n_err++; $display("FAIL load_branch_stall1: got %0b expected 1", bus.stall);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (bus.stall !== 1'b1) begin
            n_err++; $display("FAIL load_branch_stall2: got %0b expected 1", bus.stall);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (bus.stall !== 1'b0 || bus.fwd_rs_d !== 2'd2) begin
            n_err++;
            $display("FAIL load_branch_release: stall=%0b fwd_rs_d=%0d expected 0/2", bus.stall, bus.fwd_rs_d);
        end
    endtask

    task automatic test_zero_and_priority();
        apply_reset();
        @(negedge clk); drive(1, 0, 2, 0, 2, 0, 2); #1;
        @(negedge clk); drive(1, 0, 0, 0, 0, 0, 1); #1;
        n_cmp++;
        if (bus.stall !== 1'b0 || bus.fwd_rs_d !== 2'd0) begin
            n_err++;
            $display("FAIL reg0_no_match: stall=%0b fwd_rs_d=%0d expected 0/0", bus.stall, bus.fwd_rs_d);
        end
        @(negedge clk); drive(1, 0, 2, 0, 2, 5, 1); #1;
        @(negedge clk); drive(1, 0, 2, 0, 2, 5, 1); #1;
        @(negedge clk); drive(1, 5, 1, 0, 2, 0, 0); #1;
        n_cmp++;
        if (bus.stall !== 1'b0 || bus.fwd_rs_d !== 2'd1) begin
            n_err++;
            $display("FAIL prio_d: stall=%0b fwd_rs_d=%0d expected 0/1", bus.stall, bus.fwd_rs_d);
        end
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0); #1;
        n_cmp++;
        if (bus.fwd_rs_e !== 2'd1) begin
            n_err++; $display("FAIL prio_e_m_over_w: got %0d expected 1", bus.fwd_rs_e);
        end
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        @(negedge clk); drive(1, 0, 2, 0, 2, 8, 2); #1;
        @(negedge clk); drive(1, 8, 1, 0, 2, 0, 0); #1;
        n_cmp++;
        if (bus.stall !== 1'b1) begin
            n_err++; $display("FAIL mid_stall_pre: got %0b expected 1", bus.stall);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.stall !== 1'b0) begin
            n_err++; $display("FAIL mid_stall_async_drop: got %0b expected 0", bus.stall);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.stall !== 1'b0) begin
            n_err++; $display("FAIL mid_stall_after: got %0b expected 0", bus.stall);
        end
`ifdef FWD_STALL_CNT_EN
        n_cmp++;
        if (stall_cnt !== 32'd0) begin
            n_err++; $display("FAIL mid_stall_cnt: got %0d expected 0", stall_cnt);
        end
`endif
    endtask

    task automatic test_random();
        bit v;
        bit e_st;
        int rs, rt, trs, trt, dst, tnew;
        int e_rs_d, e_rt_d, e_rs_e, e_rt_e;
        int n_stall;
        apply_reset();
        n_stall = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            v    = ($urandom_range(0, 3) != 0);
            rs   = $urandom_range(0, 3);
            rt   = $urandom_range(0, 3);
            trs  = $urandom_range(0, 2);
            trt  = $urandom_range(0, 2);
            dst  = $urandom_range(0, 3);
            tnew = $urandom_range(0, 2);
            drive(v, rs, trs, rt, trt, dst, tnew);
            #1;
            e_st   = v && (needs_stall(rs, trs) || needs_stall(rt, trt));
            e_rs_d = exp_sel(rs);
            e_rt_d = exp_sel(rt);
            e_rs_e = exp_sel(hist[0].rs);
            e_rt_e = exp_sel(hist[0].rt);
            n_cmp++;
            if (bus.stall !== e_st) begin
                n_err++; $display("FAIL rnd_stall[%0d]: got %0b expected %0b", c, bus.stall, e_st);
            end
            n_cmp++;
            if (bus.fwd_rs_d !== 2'(e_rs_d) || bus.fwd_rt_d !== 2'(e_rt_d)) begin
                n_err++;
                $display("FAIL rnd_fwd_d[%0d]: got %0d/%0d expected %0d/%0d",
                         c, bus.fwd_rs_d, bus.fwd_rt_d, e_rs_d, e_rt_d);
            end
            n_cmp++;
            if (bus.fwd_rs_e !== 2'(e_rs_e) || bus.fwd_rt_e !== 2'(e_rt_e)) begin
                n_err++;
                $display("FAIL rnd_fwd_e[%0d]: got %0d/%0d expected %0d/%0d",
                         c, bus.fwd_rs_e, bus.fwd_rt_e, e_rs_e, e_rt_e);
            end
            if (e_st) n_stall++;
            void'(hist.pop_back());
            if (v && !e_st) hist.push_front('{dst, tnew, rs, rt});
            else            hist.push_front('{0, 0, 0, 0});
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
`ifdef FWD_STALL_CNT_EN
        n_cmp++;
        if (stall_cnt !== 32'(n_stall)) begin
            n_err++; $display("FAIL rnd_stall_cnt: got %0d expected %0d", stall_cnt, n_stall);
        end
`else
        if (n_stall == 0) $display("note: random run produced no stalls");
`endif
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_clear();
        test_reset();
        test_alu_alu();
        test_load_use();
        test_load_branch();
        test_zero_and_priority();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
